// File: rtl/seg_scan_6.sv
// seg_scan_6: six-digit multiplexed common-cathode 7-segment scan driver.
// Snapshots the time digits once per frame, then walks slots 0..5 with a
// guard interval, leading-zero blanking, per-slot blink and colon dots.
module seg_scan_6 #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned GUARD     = 500,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] hour_t,
  input  logic [3:0] hour_o,
  input  logic [3:0] min_t,
  input  logic [3:0] min_o,
  input  logic [3:0] sec_t,
  input  logic [3:0] sec_o,
  input  logic       lz_blank,
  input  logic [5:0] blink_mask,
  input  logic       dp_en,
  output logic [7:0] seg,
  output logic [5:0] com
);

  localparam int unsigned DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned SLOT_W  = 3;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0]   GUARD_END  = DIV_W'(GUARD);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(5);

  localparam logic [5:0] COM_OFF = 6'h3F;
  localparam logic [6:0] GLYPH_DASH = 7'h40;

  // Frame snapshot of all six digits (23 bits).
  typedef struct packed {
    logic [2:0] hour_t;
    logic [3:0] hour_o;
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
  } digits_t;

  logic [DIV_W-1:0]   div_cnt,   div_nxt;
  logic [SLOT_W-1:0]  slot,      slot_nxt;
  logic [BLINK_W-1:0] blink_cnt, blink_nxt;
  logic               blink_ph,  blink_ph_nxt;
  logic               load_pending, load_pending_nxt;
  digits_t            snap,      snap_nxt;
  logic [7:0]         seg_nxt;
  logic [5:0]         com_nxt;

  logic               tick_c;
  logic               blink_tc_c;
  logic               load_c;
  logic [3:0]         digit_c;
  logic [5:0]         slot_oh_c;
  logic [6:0]         glyph_c;
  logic               blink_hide_c;
  logic               lz_hide_c;

  // Next-state for prescaler, slot pointer, blink phase and snapshot.
  always_comb begin
    tick_c           = (div_cnt == DIV_LAST);
    blink_tc_c       = (blink_cnt == BLINK_LAST);
    load_c           = load_pending | (tick_c & (slot == SLOT_LAST));

    div_nxt          = div_cnt + DIV_W'(1);
    slot_nxt         = slot;
    blink_nxt        = blink_cnt + BLINK_W'(1);
    blink_ph_nxt     = blink_ph;
    snap_nxt         = snap;
    // The pending load always happens on the first cycle out of reset.
    load_pending_nxt = 1'b0;

    if (tick_c) begin
      div_nxt  = '0;
      slot_nxt = (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
    end

    if (blink_tc_c) begin
      blink_nxt    = '0;
      blink_ph_nxt = ~blink_ph;
    end

    if (load_c) begin
      snap_nxt.hour_t = hour_t;
      snap_nxt.hour_o = hour_o;
      snap_nxt.min_t  = min_t;
      snap_nxt.min_o  = min_o;
      snap_nxt.sec_t  = sec_t;
      snap_nxt.sec_o  = sec_o;
    end
  end

  // Select the current slot's digit, decode it and apply blanking.
  always_comb begin
    digit_c      = 4'd0;
    glyph_c      = GLYPH_DASH;
    slot_oh_c    = 6'b000001 << slot;
    blink_hide_c = 1'b0;
    lz_hide_c    = 1'b0;
    seg_nxt      = 8'h00;
    com_nxt      = COM_OFF;

    case (slot)
      3'd0:    digit_c = {1'b0, snap.hour_t};
      3'd1:    digit_c = snap.hour_o;
      3'd2:    digit_c = snap.min_t;
      3'd3:    digit_c = snap.min_o;
      3'd4:    digit_c = snap.sec_t;
      3'd5:    digit_c = snap.sec_o;
      default: digit_c = 4'd0;
    endcase

    case (digit_c)
      4'd0:    glyph_c = 7'h3F;
      4'd1:    glyph_c = 7'h06;
      4'd2:    glyph_c = 7'h5B;
      4'd3:    glyph_c = 7'h4F;
      4'd4:    glyph_c = 7'h66;
      4'd5:    glyph_c = 7'h6D;
      4'd6:    glyph_c = 7'h7D;
      4'd7:    glyph_c = 7'h07;
      4'd8:    glyph_c = 7'h7F;
      4'd9:    glyph_c = 7'h6F;
      default: glyph_c = GLYPH_DASH;
    endcase

    // Hours tens only ranges 0..2; anything larger is shown as a dash.
    if ((slot == 3'd0) && (digit_c > 4'd2)) begin
      glyph_c = GLYPH_DASH;
    end

    blink_hide_c = (|(blink_mask & slot_oh_c)) & ~blink_ph;
    lz_hide_c    = (slot == 3'd0) & lz_blank & (snap.hour_t == 3'd0);

    seg_nxt[6:0] = glyph_c;
    if (blink_hide_c || lz_hide_c) begin
      seg_nxt[6:0] = 7'h00;
    end
    seg_nxt[7] = dp_en & ((slot == 3'd1) | (slot == 3'd3)) & ~blink_hide_c;

    com_nxt = (div_cnt < GUARD_END) ? COM_OFF : ~slot_oh_c;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt      <= '0;
      slot         <= '0;
      blink_cnt    <= '0;
      blink_ph     <= 1'b1;
      load_pending <= 1'b1;
      snap         <= '0;
      seg          <= 8'h00;
      com          <= COM_OFF;
    end else begin
      div_cnt      <= div_nxt;
      slot         <= slot_nxt;
      blink_cnt    <= blink_nxt;
      blink_ph     <= blink_ph_nxt;
      load_pending <= load_pending_nxt;
      snap         <= snap_nxt;
      seg          <= seg_nxt;
      com          <= com_nxt;
    end
  end

endmodule

// File: doc/seg_scan_6.md
# seg_scan_6

Six-digit multiplexed 7-segment scan driver for the digital-clock display path. It sits directly downstream of the time-keeping counter chain: hours-tens (0..2), hours-ones, minutes and seconds digits. It takes the six BCD digits, snapshots them once per scan frame, and drives one digit at a time onto a common-cathode display. It adds leading-zero blanking, per-digit blink for time-set mode, colon dots and an anti-ghosting guard interval.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot; legal range ≥ 2.
- GUARD, 500: cycles at the start of each slot with all digits off; legal range 0 ≤ GUARD < SCAN_DIV.
- BLINK_DIV, 25000000: clock cycles per blink half-period.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- hour_t  in  3  hours tens digit (0..2 valid).
- hour_o  in  4  hours ones digit (BCD).
- min_t, min_o  in  4 each  minutes tens/ones (BCD).
- sec_t, sec_o  in  4 each  seconds tens/ones (BCD).
- lz_blank  in  1  1 = blank the hours-tens digit when it is 0.
- blink_mask  in  6  bit k = 1 makes slot k blink.
- dp_en  in  1  1 = light the dots on slots 1 and 3 (colon).
- seg  out  8  {dp,g,f,e,d,c,b,a}; active-high.
- com  out  6  digit enables; active-low; com[k] drives slot k.

## Operation
- Slot order: 0 hour_t, 1 hour_o, 2 min_t, 3 min_o, 4 sec_t, 5 sec_o.
- Prescaler div_cnt counts 0..SCAN_DIV-1 and wraps. A tick occurs when div_cnt == SCAN_DIV-1.
- On tick, slot advances: slot = (slot == 5) ? 0 : slot+1.
- Snapshot register (6 digits, 23 bits) loads all digit inputs in two cases:
  - on a tick with slot == 5, so each new frame starts with a coherent time;
  - on the first cycle after rst deasserts. A load_pending flag is set by reset and cleared by that load.
- Digits are displayed only from the snapshot; input changes mid-frame must not appear until the next frame.
- Blink counter counts 0..BLINK_DIV-1. blink_ph toggles at terminal count; blink_ph = 1 means visible.
- Decode of the snapshot digit in the current slot (seg[6:0]):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F;
  - any value > 9 displays dash 0x40; hour_t values 3..7 also display dash.
- Segment blanking, in priority order, forces seg[6:0] = 0:
  - blink_mask[slot] && !blink_ph;
  - slot == 0 && lz_blank && hour_t_snap == 0.
- seg[7] = dp_en && (slot == 1 || slot == 3). Dot blanking applies only when blink hides that slot.
- com = 6'h3F when div_cnt < GUARD; otherwise com = ~(6'b1 << slot). Blanked digits still assert com (segments off).
- blink_mask, lz_blank and dp_en are used live, not snapshotted.

## Timing
- seg and com are registered. They reflect (slot, div_cnt, snapshot, blink_ph, live controls) of the previous cycle: 1-cycle latency.
- Reset values while rst = 1 and on the first cycle after release:
  - div_cnt = 0, slot = 0, blink counter = 0, blink_ph = 1, load_pending = 1;
  - snapshot = all 0;
  - outputs com = 6'h3F, seg = 8'h00.
- With GUARD = 0, com never goes all-off except in reset.
- Each slot lasts exactly SCAN_DIV cycles; a frame lasts 6·SCAN_DIV cycles.
- rst mid-frame aborts the frame. The next cycle shows all-off outputs, and scanning restarts at slot 0 with a fresh snapshot.
- Simultaneous tick and blink toggle: both take effect on the same edge, with no priority interaction.

## Test plan
Benches use SCAN_DIV = 4, GUARD = 1, BLINK_DIV = 16.
- Reset, then time 12:34:56 with lz_blank = 0, dp_en = 0, mask = 0 -> com cycles 3E, 3D, 3B, 37, 2F, 1F, with 3F for the first cycle of each slot. seg per slot = 06, 5B, 4F, 66, 6D, 7D.
- hour_t = 0, lz_blank = 1 -> slot 0 has com = 3E with seg = 00. With lz_blank = 0, seg = 3F.
- Change sec_o 6->7 during slot 2 -> slot 5 still shows 7D this frame and shows 07 in the next frame.
- dp_en = 1 -> seg = 0xDB on slot 1 for digit 2, and the dot is set on slot 3. Dots are off on all other slots.
- blink_mask = 6'b000011 -> slots 0..1 show seg 00 for 16 cycles, then normal for 16 cycles, repeating. The other slots are unaffected.
- min_t = 4'hC and hour_t = 3'd5 -> those slots show 0x40. Assert rst during slot 3 -> the next cycle has com = 3F and seg = 00, and scanning resumes at slot 0.
